// File: rtl/d_flip_flop_en_if.sv
// d_flip_flop_en_if: load-enable/data/output bundle for the enabled storage register
interface d_flip_flop_en_if #(parameter int WIDTH = 1);
  logic             en;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  modport master (output en, output d, input q);
  modport slave (input en, input d, output q);
endinterface

// File: rtl/d_flip_flop_en.sv
// d_flip_flop_en: enabled D register with synchronous active-low reset
module d_flip_flop_en #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                clk,
  input logic                reset,
  d_flip_flop_en_if.slave    bus
);
  always_ff @(posedge clk)
    bus.q <= !reset ? RESET_VAL : bus.en ? bus.d : bus.q;
endmodule

// File: tb/tb_d_flip_flop_en.sv
// tb_d_flip_flop_en: directed checks of a 1-bit and an 8-bit instance against a bench model
module tb_d_flip_flop_en;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  logic       ma;
  logic [7:0] mb;
  logic       valid = 1'b0;

  always #5 clk = ~clk;

  d_flip_flop_en_if #(.WIDTH(1)) ia ();
  d_flip_flop_en_if #(.WIDTH(8)) ib ();

  d_flip_flop_en #(.WIDTH(1), .RESET_VAL(1'b0)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
  d_flip_flop_en #(.WIDTH(8), .RESET_VAL(8'hA5)) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));

  // Model: what each register must hold after an edge, from the priority rule
  always @(posedge clk) begin
    if (reset === 1'b0) begin
      ma <= 1'b0;
      mb <= 8'hA5;
      valid <= 1'b1;
    end else begin
      if (ia.en) ma <= ia.d;
      if (ib.en) mb <= ib.d;
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      checks += 2;
      if (ia.q !== ma) begin
        errors++;
        $display("FAIL model_a: q=%b expected %b", ia.q, ma);
      end
      if (ib.q !== mb) begin
        errors++;
        $display("FAIL model_b: q=%h expected %h", ib.q, mb);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #6;
  endtask

  task automatic drive(input logic r, input logic e, input logic da, input logic [7:0] db);
    reset = r;
    ia.en = e;
    ib.en = e;
    ia.d = da;
    ib.d = db;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    chk("reset_a", {7'd0, ia.q}, 8'h00);
    chk("reset_b", ib.q, 8'hA5);
    drive(1'b0, 1'b1, 1'b1, 8'h3C);
    step();
    chk("rst_prio_a", {7'd0, ia.q}, 8'h00);
    chk("rst_prio_b", ib.q, 8'hA5);
    drive(1'b1, 1'b1, 1'b1, 8'h3C);
    step();
    chk("load1_a", {7'd0, ia.q}, 8'h01);
    chk("load1_b", ib.q, 8'h3C);
    drive(1'b1, 1'b1, 1'b0, 8'h5A);
    step();
    chk("load0_a", {7'd0, ia.q}, 8'h00);
    chk("load0_b", ib.q, 8'h5A);
    drive(1'b1, 1'b0, 1'b1, 8'hFF);
    step();
    step();
    chk("hold_a", {7'd0, ia.q}, 8'h00);
    chk("hold_b", ib.q, 8'h5A);
    drive(1'b1, 1'b1, 1'b1, 8'hFF);
    step();
    chk("reload_a", {7'd0, ia.q}, 8'h01);
    chk("reload_b", ib.q, 8'hFF);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    #2;
    chk("async_a", {7'd0, ia.q}, 8'h01);
    chk("async_b", ib.q, 8'hFF);
    step();
    chk("async_edge_a", {7'd0, ia.q}, 8'h01);
    chk("async_edge_b", ib.q, 8'hFF);
    drive(1'b0, 1'b1, 1'b1, 8'h00);
    step();
    chk("rst2_a", {7'd0, ia.q}, 8'h00);
    chk("rst2_b", ib.q, 8'hA5);
    for (int i = 0; i < 40; i++) begin
      drive(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), 8'($urandom));
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
